// File: rtl/fetch_sequencer.sv
// Fetch-side next-PC / stall / flush sequencer with boot hold, halt and deferred redirects.
// Optional exception redirect to EXC_VECTOR is enabled by defining FETCH_SEQ_EXC_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BOOT_CYCLES = 4,
    parameter logic [31:0] EXC_VECTOR  = 32'h0000_0180
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        StallF,
    input  logic [31:0] PCPlus4F,
    input  logic        BranchTakenE,
    input  logic [31:0] BranchTargetE,
    input  logic        JumpD,
    input  logic [31:0] JumpTargetD,
    input  logic        HaltD,
    input  logic        ResumeReq,
    input  logic        ExcReq,
    output logic [31:0] PCin,
    output logic        StallFOut,
    output logic        FlushD,
    output logic        FlushE,
    output logic [15:0] StallCount
);

    typedef enum logic [1:0] {BOOT, RUN, PEND, HALT} state_t;

    state_t      state, nstate;
    logic [7:0]  bcnt, nbcnt;
    logic        pvld, npvld;
    logic [31:0] ptgt, nptgt;
    logic        pfe, npfe;
    logic [1:0]  pprio, npprio;

    logic        exc;
`ifdef FETCH_SEQ_EXC_EN
    assign exc = ExcReq;
`else
    logic unused_exc;
    assign unused_exc = ExcReq;
    assign exc = 1'b0;
`endif

    logic        rvld, rfe, take;
    logic [1:0]  rprio;
    logic [31:0] rtgt;

    // Priority: exception > branch > jump; rfe marks flushes reaching Execute.
    always_comb begin
        rvld  = exc | BranchTakenE | JumpD;
        rprio = 2'd0;
        rtgt  = JumpTargetD;
        rfe   = 1'b0;
        if (exc) begin
            rprio = 2'd2;
            rtgt  = EXC_VECTOR;
            rfe   = 1'b1;
        end else if (BranchTakenE) begin
            rprio = 2'd1;
            rtgt  = BranchTargetE;
            rfe   = 1'b1;
        end
        take = rvld && (!pvld || rprio >= pprio);
    end

    always_comb begin
        nstate    = state;
        nbcnt     = bcnt;
        npvld     = pvld;
        nptgt     = ptgt;
        npfe      = pfe;
        npprio    = pprio;
        PCin      = PCPlus4F;
        StallFOut = StallF;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        unique case (state)
            BOOT: begin
                PCin      = RESET_PC;
                StallFOut = 1'b1;
                nbcnt     = bcnt + 8'd1;
                if (bcnt == 8'(BOOT_CYCLES - 1))
                    nstate = RUN;
            end
            RUN, HALT: begin
                if (state == HALT)
                    StallFOut = 1'b1;
                if ((state == RUN && rvld) || (state == HALT && exc)) begin
                    if (!StallF) begin
                        PCin      = rtgt;
                        StallFOut = 1'b0;
                        FlushD    = 1'b1;
                        FlushE    = rfe;
                        nstate    = RUN;
                    end else begin
                        npvld  = 1'b1;
                        nptgt  = rtgt;
                        npfe   = rfe;
                        npprio = rprio;
                        nstate = PEND;
                    end
                end else if (state == RUN && HaltD && !StallF) begin
                    FlushD = 1'b1;
                    nstate = HALT;
                end else if (state == HALT && ResumeReq) begin
                    nstate = RUN;
                end
            end
            PEND: begin
                if (take) begin
                    nptgt  = rtgt;
                    npfe   = rfe;
                    npprio = rprio;
                end
                if (!StallF) begin
                    PCin   = take ? rtgt : ptgt;
                    FlushD = 1'b1;
                    FlushE = take ? rfe : pfe;
                    npvld  = 1'b0;
                    nstate = RUN;
                end
            end
            default: nstate = BOOT;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= BOOT;
            bcnt       <= 8'd0;
            pvld       <= 1'b0;
            ptgt       <= 32'd0;
            pfe        <= 1'b0;
            pprio      <= 2'd0;
            StallCount <= 16'd0;
        end else begin
            state      <= nstate;
            bcnt       <= nbcnt;
            pvld       <= npvld;
            ptgt       <= nptgt;
            pfe        <= npfe;
            pprio      <= npprio;
            StallCount <= StallCount + 16'(StallFOut);
        end
    end

endmodule
